uart_rx_byte: RTL and testbench
===============================

UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clk cycles per serial bit (115200 baud at 10 MHz); legal range 4..65535.
REQ-002 Parameter PARITY_ODD, default 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
REQ-003 clk  input  1  system clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 frame (8E1/8O1 with parity).
REQ-006 data  output  8  received byte, LSB = first data bit on the line.
REQ-007 valid  output  1  data holds an unconsumed byte.
REQ-008 ready  input  1  consumer accepts data when valid && ready on a clk edge.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 without parity.
REQ-011 overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being drained.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx passes through a 2-flop synchronizer (both flops reset to 1) before any use; all sampling uses the synchronized value.
REQ-014 FSM states: IDLE, START, DATA, PARITY (present only with parity), STOP.
REQ-015 IDLE -> START on a synchronized falling edge (previous 1, current 0); the baud counter clears on entry.
REQ-016 START: sample at count CLKS_PER_BIT/2 (integer division); 0 -> DATA, counter clears; 1 -> IDLE (false start, no output or flags).
REQ-017 DATA: sample every CLKS_PER_BIT cycles, shift in LSB first; after the 8th sample -> PARITY (parity) or STOP.
REQ-018 PARITY: sample after CLKS_PER_BIT cycles; compare against XOR of the data bits (inverted when PARITY_ODD = 1); -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT cycles, then -> IDLE unconditionally.
REQ-020 Stop = 1 and no parity error: byte is delivered to the holding register (REQ-022).
REQ-021 Stop = 0: frame_err pulses and the byte is discarded; when parity also fails, only frame_err pulses.
REQ-022 Parity mismatch with stop = 1: parity_err pulses and the byte is discarded.
REQ-023 Delivery: data and valid update on the clk edge after the stop-bit sample edge; latency from the stop-bit sample point to valid = 1 clk.
REQ-024 valid stays high and data stays stable until a valid && ready edge; valid then clears unless REQ-025 applies.
REQ-025 Delivery on the same edge as valid && ready: the new byte loads, valid stays 1, no overrun.
REQ-026 Delivery while valid && !ready: overrun pulses, the new byte is dropped, and the held byte is kept.
REQ-027 A line held low after a frame error (break) causes no new frame until rx returns high and falls again.
REQ-028 ready while valid = 0 has no effect.

Reset
REQ-029 Asserting rst_n asynchronously forces IDLE, clears the counter and shift register, sets the synchronizer flops to 1, and drives data = 0x00, valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0.
REQ-030 Reset mid-frame abandons the frame; after release, reception restarts only on the next falling edge.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: the PARITY state and parity check are built; the frame carries 1 parity bit after the data.
REQ-032 UART_RX_PARITY_EN undefined: no PARITY state, 8N1 framing, parity_err tied to 0; PARITY_ODD is ignored.

Verification
REQ-033 8N1 byte 0xA5 at CLKS_PER_BIT = 87 with ready = 1 -> data = 0xA5 and valid high for 1 cycle; all error flags stay 0.
REQ-034 rx low for 20 cycles then high (glitch) -> no START-to-DATA transition; valid, frame_err and busy return to 0 with no output.
REQ-035 Byte 0x3C with stop bit forced 0 -> frame_err pulses once and valid stays 0; a following good byte 0x55 -> data = 0x55.
REQ-036 ready = 0; send 0x11 then 0x22 -> valid = 1 with data = 0x11, overrun pulses at the 0x22 stop bit; ready = 1 -> valid drops.
REQ-037 UART_RX_PARITY_EN, even parity; send 0x07 with parity bit 0 -> parity_err pulses and no valid; parity bit 1 -> data = 0x07.
REQ-038 rst_n pulsed low during data bit 4 of 0xFF -> outputs take their reset values immediately; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8-bit asynchronous serial receiver with a one-entry holding register.
// Frame is 8N1 by default. Defining UART_RX_PARITY_EN adds a parity bit after the data
// (8E1 or 8O1, selected by PARITY_ODD). Frames with a bad stop bit or bad parity are
// discarded and flagged with a one-cycle pulse.

module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] HalfCnt = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);
    localparam logic        ParOdd  = (PARITY_ODD != 0);
`ifdef UART_RX_PARITY_EN
    localparam logic        ParEn   = 1'b1;
`else
    localparam logic        ParEn   = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sreg_q, sreg_d;
    logic        par_bit_q, par_bit_d;
    logic        fin_q, fin_d;
    logic        stop_q, stop_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;

    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        overrun_q, overrun_d;
    logic        par_bad;
    logic        deliver;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            sreg_q    <= '0;
            par_bit_q <= 1'b0;
            fin_q     <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sreg_q    <= sreg_d;
            par_bit_q <= par_bit_d;
            fin_q     <= fin_d;
            stop_q    <= stop_d;
        end
    end

    // Frame FSM next state: bit timing, sampling and shifting; fin_d marks the stop sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sreg_d    = sreg_q;
        par_bit_d = par_bit_q;
        fin_d     = 1'b0;
        stop_d    = stop_q;
        case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rx_sync_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (cnt_q == LastCnt) begin
                    cnt_d  = '0;
                    sreg_d = {rx_sync_q, sreg_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == LastCnt) begin
                    cnt_d     = '0;
                    par_bit_d = rx_sync_q;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    fin_d   = 1'b1;
                    stop_d  = rx_sync_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Parity is only ever flagged when the parity bit is built in.
    assign par_bad = ParEn & (par_bit_q ^ (^sreg_q) ^ ParOdd);
    assign deliver = fin_q & stop_q & ~par_bad;

    // Holding register and error pulses, resolved one cycle after the stop sample.
    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = fin_q & ~stop_q;
        parity_err_d = fin_q & stop_q & par_bad;
        overrun_d    = 1'b0;
        if (deliver) begin
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = sreg_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: scoreboard bench for uart_rx_byte. Each sent frame is classified at the
// frame level (byte, frame error, parity error, overrun) and queued; a forked monitor pops
// and compares every output event, including a timing window around the stop-bit centre.

module tb_uart_rx_byte;

    localparam int unsigned N    = 87;
    localparam int unsigned HALF = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PB   = 1;
`else
    localparam int unsigned PB   = 0;
`endif
    localparam logic PAR_ODD = 1'b0;

    typedef enum logic [1:0] {EvByte, EvFerr, EvPerr, EvOvr} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [7:0]  data;
        int unsigned t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    bit          model_hold = 1'b0;

    uart_rx_byte #(
        .CLKS_PER_BIT(N),
        .PARITY_ODD  (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pop the next expected event and compare kind, data and arrival time.
    task automatic got(input ev_kind_e k);
        exp_t        e;
        int unsigned lo;
        int unsigned hi;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected no event (cycle %0d)", k, cyc);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 32'(k), 32'(e.kind));
        if (k == EvByte) check("event_data", 32'(data), 32'(e.data));
        // Stop-bit centre on the line plus synchronizer and output register delay.
        lo = e.t0 + (9 + PB) * N + HALF + 3;
        hi = lo + 4;
        n_checks++;
        if (cyc < lo || cyc > hi) begin
            n_fail++;
            $display("FAIL event_time: got cycle %0d, expected %0d..%0d", cyc, lo, hi);
        end
    endtask

    task automatic monitor();
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b0;
                pd = 8'h00;
                continue;
            end
            if (pv && !pr && valid) check("data_stable", 32'(data), 32'(pd));
            if (frame_err) got(EvFerr);
            if (parity_err) got(EvPerr);
            if (overrun) got(EvOvr);
            // A new byte is valid after an idle or a completed handshake.
            if (valid && (!pv || pr)) got(EvByte);
            pv = valid;
            pr = ready;
            pd = data;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                              input bit keep_low);
        exp_t e;
        logic par_good;
        par_good = (par_bit == ((^b) ^ PAR_ODD));
        @(posedge clk);
        #1;
        e.t0   = cyc;
        e.data = b;
        if (!stop_bit) e.kind = EvFerr;
        else if (PB == 1 && !par_good) e.kind = EvPerr;
        else if (model_hold && !ready) e.kind = EvOvr;
        else begin
            e.kind     = EvByte;
            model_hold = !ready;
        end
        exp_q.push_back(e);
        rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (N) @(posedge clk);
            #1;
            rx = b[i];
        end
        if (PB == 1) begin
            repeat (N) @(posedge clk);
            #1;
            rx = par_bit;
        end
        repeat (N) @(posedge clk);
        #1;
        rx = stop_bit;
        repeat (N) @(posedge clk);
        #1;
        if (!stop_bit && !keep_low) begin
            rx = 1'b1;
            repeat (N) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(data), 32'h00);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        logic       rperr;
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'h0);

        // Basic byte with consumer always ready.
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("a5_flags", 32'({valid, frame_err, parity_err, overrun, busy}), 32'h0);

        // Short low glitch: START is entered but aborted, nothing is produced.
        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("glitch_busy_high", 32'(busy), 32'h1);
        repeat (10) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (N) @(posedge clk);
        #1;
        check("glitch_busy_low", 32'(busy), 32'h0);
        check("glitch_valid", 32'(valid), 32'h0);

        // Bad stop bit, then line held low (break), then a good byte.
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b1);
        repeat (3 * N) @(posedge clk);
        #1;
        check("break_busy", 32'(busy), 32'h0);
        check("break_valid", 32'(valid), 32'h0);
        rx = 1'b1;
        repeat (2 * N) @(posedge clk);
        send_frame(8'h55, 1'b1, ^8'h55, 1'b0);

        // Overrun: consumer stalled for two bytes.
        ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11, 1'b0);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
        repeat (N) @(posedge clk);
        #1;
        check("ovr_held_valid", 32'(valid), 32'h1);
        check("ovr_held_data", 32'(data), 32'h11);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_drained_valid", 32'(valid), 32'h0);
        model_hold = 1'b0;

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity requires a 1.
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
`endif

        // Reset in the middle of data bit 4 of 0xFF while a byte is held.
        ready = 1'b0;
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
        rx = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4 * N + HALF) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'h1);
        check("pre_reset_valid", 32'(valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready      = 1'b1;
        model_hold = 1'b0;
        repeat (6 * N) @(posedge clk);
        #1;
        check("post_reset_busy", 32'(busy), 32'h0);
        send_frame(8'h81, 1'b1, ^8'h81, 1'b0);

        // Random frames with occasional framing and parity faults.
        for (int k = 0; k < 20; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 7) != 0);
            rperr = ($urandom_range(0, 5) == 0);
            send_frame(rb, rstop, (^rb) ^ PAR_ODD ^ rperr, 1'b0);
            repeat ($urandom_range(0, N)) @(posedge clk);
        end

        repeat (3 * N) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
